dbf_scan_ctrl: RTL and testbench

- Per-scan-line sequencer for the DBF channel array (all dbf_chNN instances share its outputs).
- Each line runs four steps: load the coarse/fine delay LUTs from a streamed config source, drive the transmit window (tx_en), open the receive/beamform window (start), then report completion.
- Sits between the system scan controller and the channel bank, and owns the shared dbf_lut_addr/dbf_lut_we/write-data bus.

---
 rtl/dbf_scan_ctrl_pkg.sv | 20 ++
 rtl/dbf_scan_ctrl_if.sv | 37 +++
 rtl/dbf_scan_ctrl_dur_timer.sv | 31 +++
 rtl/dbf_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_dbf_scan_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbf_scan_ctrl_pkg.sv
// dbf_scan_ctrl_pkg: shared definitions for the DBF per-scan-line sequencer.
//   - state_t       : sequencer states (IDLE, LOAD, TX, RX, DONE)
//   - DEF_ADDR_WD   : default LUT address width
//   - DEF_LUT_DATA_WD : default LUT write-data width
//   - DEF_CNT_WD    : default duration counter width
package dbf_scan_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WD     = 8;
    localparam int unsigned DEF_LUT_DATA_WD = 16;
    localparam int unsigned DEF_CNT_WD      = 12;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_TX   = 3'd2,
        S_RX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/dbf_scan_ctrl_if.sv
// dbf_scan_ctrl_if: config stream + shared channel LUT write bus.
//   cfg_valid/cfg_data/cfg_ready   : streamed LUT config words (valid/ready)
//   dbf_lut_addr/we/wdata          : LUT write bus fanned out to all channels
// Modports:
//   master : the scan controller (consumes config, drives the LUT bus)
//   slave  : config source / channel bank side
interface dbf_scan_ctrl_if
    import dbf_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WD     = DEF_ADDR_WD,
    parameter int unsigned LUT_DATA_WD = DEF_LUT_DATA_WD
);
    logic                   cfg_valid;
    logic [LUT_DATA_WD-1:0] cfg_data;
    logic                   cfg_ready;
    logic [ADDR_WD-1:0]     dbf_lut_addr;
    logic                   dbf_lut_we;
    logic [LUT_DATA_WD-1:0] dbf_lut_wdata;

    modport master (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output dbf_lut_addr,
        output dbf_lut_we,
        output dbf_lut_wdata
    );

    modport slave (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  dbf_lut_addr,
        input  dbf_lut_we,
        input  dbf_lut_wdata
    );
endinterface

// File: rtl/dbf_scan_ctrl_dur_timer.sv
// dbf_dur_timer: loadable down-counter with terminal-count flag.
// Shared between the TX and RX windows of the scan sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (has priority over counting)
//   load_val   : value loaded; window length is load_val + 1 cycles
//   tc         : high while the count is zero
module dbf_dur_timer
    import dbf_scan_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WD = DEF_CNT_WD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_val,
    output logic              tc
);
    logic [CNT_WD-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/dbf_scan_ctrl.sv
// dbf_scan_ctrl: per-scan-line sequencer for the DBF channel array.
// Each line: load LUTs from the config stream, tx window, rx window, done.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   line_start  : single-cycle request to run one line (ignored unless idle)
//   abort       : (only with DBF_SCAN_ABORT_EN) cut the line short to DONE
//   busy        : high from line acceptance until line_done
//   line_done   : one-cycle pulse at end of line
//   tx_en       : transmit window, TX_CYCLES cycles
//   start       : receive/beamform window, RX_SAMPLES cycles
//   bus         : config stream + LUT write bus (master side)
// Optional feature macro: DBF_SCAN_ABORT_EN.
module dbf_scan_ctrl
    import dbf_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WD     = DEF_ADDR_WD,
    parameter int unsigned LUT_DEPTH   = 128,
    parameter int unsigned LUT_DATA_WD = DEF_LUT_DATA_WD,
    parameter int unsigned TX_CYCLES   = 16,
    parameter int unsigned RX_SAMPLES  = 2048,
    parameter int unsigned CNT_WD      = DEF_CNT_WD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_start,
`ifdef DBF_SCAN_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    output logic line_done,
    output logic tx_en,
    output logic start,
    dbf_scan_ctrl_if.master bus
);
    state_t             state;
    state_t             state_nxt;
    logic [ADDR_WD-1:0] wr_cnt;
    logic               abort_req;
    logic               hs;
    logic               last_word;
    logic               tmr_load;
    logic [CNT_WD-1:0]  tmr_val;
    logic               tmr_tc;

`ifdef DBF_SCAN_ABORT_EN
    assign abort_req = abort && (state == S_LOAD || state == S_TX || state == S_RX);
`else
    assign abort_req = 1'b0;
`endif

    assign bus.cfg_ready = (state == S_LOAD);
    // An abort wins over a concurrent config handshake: the word is dropped.
    assign hs        = bus.cfg_valid && bus.cfg_ready && !abort_req;
    assign last_word = (wr_cnt == ADDR_WD'(LUT_DEPTH - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (line_start)       state_nxt = S_LOAD;
            S_LOAD: if (hs && last_word)  state_nxt = S_TX;
            S_TX:   if (tmr_tc)           state_nxt = S_RX;
            S_RX:   if (tmr_tc)           state_nxt = S_DONE;
            S_DONE:                       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
        if (abort_req) state_nxt = S_DONE;
    end

    // The timer reloads on every state change, so TX/RX each start from a
    // fresh count and the other states leave it parked at zero.
    always_comb begin
        tmr_load = (state_nxt != state);
        tmr_val  = '0;
        if (state_nxt == S_TX) tmr_val = CNT_WD'(TX_CYCLES - 1);
        if (state_nxt == S_RX) tmr_val = CNT_WD'(RX_SAMPLES - 1);
    end

    dbf_dur_timer #(.CNT_WD(CNT_WD)) u_dur_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Window outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            line_done <= 1'b0;
            tx_en     <= 1'b0;
            start     <= 1'b0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            line_done <= (state_nxt == S_DONE);
            tx_en     <= (state_nxt == S_TX);
            start     <= (state_nxt == S_RX);
        end
    end

    // LUT write path: one registered write per handshake; addr/wdata hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt            <= '0;
            bus.dbf_lut_we    <= 1'b0;
            bus.dbf_lut_addr  <= '0;
            bus.dbf_lut_wdata <= '0;
        end else begin
            bus.dbf_lut_we <= hs;
            if (hs) begin
                bus.dbf_lut_addr  <= wr_cnt;
                bus.dbf_lut_wdata <= bus.cfg_data;
            end
            if (state != S_LOAD) begin
                wr_cnt <= '0;
            end else if (hs) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// tb_dbf_scan_ctrl: self-checking bench for dbf_scan_ctrl.
// Small configuration (LUT_DEPTH=4, TX_CYCLES=3, RX_SAMPLES=5); a line-level
// model is compared against the DUT every cycle, and literal expectations
// pin the write sequence and window lengths of each directed scenario.
module tb_dbf_scan_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TXC   = 3;
    localparam int unsigned RXS   = 5;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic line_start = 1'b0;
    logic abort      = 1'b0;
    logic busy, line_done, tx_en, start;

    always #5 clk = ~clk;

    dbf_scan_ctrl_if #(.ADDR_WD(8), .LUT_DATA_WD(16)) bus ();

    dbf_scan_ctrl #(
        .ADDR_WD     (8),
        .LUT_DEPTH   (DEPTH),
        .LUT_DATA_WD (16),
        .TX_CYCLES   (TXC),
        .RX_SAMPLES  (RXS),
        .CNT_WD      (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
`ifdef DBF_SCAN_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .line_done  (line_done),
        .tx_en      (tx_en),
        .start      (start),
        .bus        (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- config source ----------------
    bit          stall_mode = 1'b0;
    logic [15:0] data_base  = 16'h00A0;
    int          rc   = 0;   // consecutive ready cycles seen so far
    int          feed = 0;   // words accepted in the current load

    always @(posedge clk) begin
        rc   <= bus.cfg_ready ? rc + 1 : 0;
        feed <= bus.cfg_ready ? feed + (bus.cfg_valid ? 1 : 0) : 0;
    end

    always @(negedge clk) begin
        bus.cfg_valid <= stall_mode ? (rc % 3 == 2) : 1'b1;
        bus.cfg_data  <= data_base + 16'(feed);
    end

    // ---------------- line-level model ----------------
    logic        m_active, m_done;
    int          m_words, m_tx, m_rx;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_done <= 1'b0;
            m_words <= 0; m_tx <= 0; m_rx <= 0;
            e_we <= 1'b0; e_addr <= '0; e_wdata <= '0;
        end else begin
            e_we <= 1'b0;
            if (!m_active) begin
                if (line_start) begin
                    m_active <= 1'b1; m_done <= 1'b0;
                    m_words <= 0; m_tx <= TXC; m_rx <= RXS;
                end
            end else if (m_done) begin
                m_active <= 1'b0; m_done <= 1'b0;
            end else if (abort) begin
                m_done <= 1'b1;
            end else if (m_words < DEPTH) begin
                if (bus.cfg_valid) begin
                    e_we    <= 1'b1;
                    e_addr  <= 8'(m_words);
                    e_wdata <= bus.cfg_data;
                    m_words <= m_words + 1;
                end
            end else if (m_tx > 0) begin
                m_tx <= m_tx - 1;
            end else begin
                m_rx <= m_rx - 1;
                if (m_rx == 1) m_done <= 1'b1;
            end
        end
    end

    wire e_ready = m_active && !m_done && (m_words < DEPTH);
    wire e_tx    = m_active && !m_done && (m_words == DEPTH) && (m_tx > 0);
    wire e_start = m_active && !m_done && (m_words == DEPTH) && (m_tx == 0) && (m_rx > 0);

    always @(negedge clk) begin
        chk("cyc_busy",  32'(busy),              32'(m_active));
        chk("cyc_done",  32'(line_done),         32'(m_done));
        chk("cyc_tx",    32'(tx_en),             32'(e_tx));
        chk("cyc_start", 32'(start),             32'(e_start));
        chk("cyc_ready", 32'(bus.cfg_ready),     32'(e_ready));
        chk("cyc_we",    32'(bus.dbf_lut_we),    32'(e_we));
        chk("cyc_addr",  32'(bus.dbf_lut_addr),  32'(e_addr));
        chk("cyc_wdata", 32'(bus.dbf_lut_wdata), 32'(e_wdata));
    end

    // ---------------- activity monitor ----------------
    int          busy_cyc = 0, tx_cyc = 0, st_cyc = 0, done_cyc = 0, wr_n = 0;
    logic [7:0]  wr_a [64];
    logic [15:0] wr_d [64];

    always @(negedge clk) begin
        if (busy)      busy_cyc <= busy_cyc + 1;
        if (tx_en)     tx_cyc   <= tx_cyc + 1;
        if (start)     st_cyc   <= st_cyc + 1;
        if (line_done) done_cyc <= done_cyc + 1;
        if (bus.dbf_lut_we && wr_n < 64) begin
            wr_a[wr_n] <= bus.dbf_lut_addr;
            wr_d[wr_n] <= bus.dbf_lut_wdata;
            wr_n       <= wr_n + 1;
        end
    end

    int s_busy, s_tx, s_st, s_done, s_wr;

    task automatic snap();
        s_busy = busy_cyc; s_tx = tx_cyc; s_st = st_cyc; s_done = done_cyc; s_wr = wr_n;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return tx_en;
            1:       return start;
            default: return line_done;
        endcase
    endfunction

    task automatic wait_for(input int s, input string name);
        int n = 0;
        while (!sig(s) && n < 400) begin
            tick();
            n++;
        end
        chk(name, 32'(sig(s)), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),              32'd0);
        chk({tag, "_done"},  32'(line_done),         32'd0);
        chk({tag, "_tx"},    32'(tx_en),             32'd0);
        chk({tag, "_start"}, 32'(start),             32'd0);
        chk({tag, "_ready"}, 32'(bus.cfg_ready),     32'd0);
        chk({tag, "_we"},    32'(bus.dbf_lut_we),    32'd0);
        chk({tag, "_addr"},  32'(bus.dbf_lut_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(bus.dbf_lut_wdata), 32'd0);
    endtask

    task automatic chk_writes(input string tag, input int first, input logic [15:0] base);
        chk({tag, "_wr_count"}, 32'(wr_n - s_wr), 32'(first + DEPTH) - 32'(s_wr) + 32'(s_wr - s_wr));
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_a[first + i]), 32'(i));
            chk($sformatf("%s_data%0d", tag, i), 32'(wr_d[first + i]), 32'(base + 16'(i)));
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic line: LOAD 4 + TX 3 + RX 5 + DONE 1 = 13 busy cycles.
        data_base = 16'h00A0;
        snap();
        pulse_start();
        wait_idle("basic_finish");
        chk_writes("basic", s_wr, 16'h00A0);
        chk("basic_busy_cycles", 32'(busy_cyc - s_busy), 32'd13);
        chk("basic_tx_cycles",   32'(tx_cyc - s_tx),     32'd3);
        chk("basic_start_cycles", 32'(st_cyc - s_st),    32'd5);
        chk("basic_done_pulses", 32'(done_cyc - s_done), 32'd1);

        // Stalled config: handshakes on LOAD cycles 2,5,8,11 -> LOAD lasts 12.
        stall_mode = 1'b1;
        data_base  = 16'h00B0;
        tick();
        snap();
        pulse_start();
        wait_idle("stall_finish");
        chk_writes("stall", s_wr, 16'h00B0);
        chk("stall_busy_cycles", 32'(busy_cyc - s_busy), 32'd21);
        chk("stall_tx_cycles",   32'(tx_cyc - s_tx),     32'd3);
        stall_mode = 1'b0;
        data_base  = 16'h00C0;
        tick();

        // line_start in LOAD, RX and DONE is ignored.
        snap();
        pulse_start();
        tick();
        pulse_start();
        wait_for(1, "ignore_reach_rx");
        pulse_start();
        wait_for(2, "ignore_reach_done");
        pulse_start();
        repeat (3) tick();
        chk("ignore_idle_after", 32'(busy), 32'd0);
        chk("ignore_done_pulses", 32'(done_cyc - s_done), 32'd1);
        chk("ignore_busy_cycles", 32'(busy_cyc - s_busy), 32'd13);
        chk_writes("ignore", s_wr, 16'h00C0);

        // Back-to-back: line_start on the first IDLE cycle after DONE.
        data_base = 16'h00D0;
        tick();
        snap();
        pulse_start();
        wait_for(2, "b2b_reach_done");
        tick();
        chk("b2b_first_idle", 32'(busy), 32'd0);
        pulse_start();
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_idle("b2b_finish");
        chk("b2b_done_pulses", 32'(done_cyc - s_done), 32'd2);
        chk("b2b_busy_cycles", 32'(busy_cyc - s_busy), 32'd26);
        chk("b2b_wr_count",    32'(wr_n - s_wr),       32'd8);
        chk("b2b_addr4",       32'(wr_a[s_wr + 4]),    32'd0);
        chk("b2b_data7",       32'(wr_d[s_wr + 7]),    32'h00D3);

        // Reset pulsed mid-RX: outputs clear without waiting for a clock.
        data_base = 16'h00E0;
        tick();
        pulse_start();
        wait_for(1, "rst_reach_rx");
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        snap();
        pulse_start();
        wait_idle("after_rst_finish");
        chk_writes("after_rst", s_wr, 16'h00E0);
        chk("after_rst_done_pulses", 32'(done_cyc - s_done), 32'd1);

`ifdef DBF_SCAN_ABORT_EN
        // Abort in the second TX cycle: tx_en lasts 2 cycles, no rx window.
        data_base = 16'h00F0;
        tick();
        snap();
        pulse_start();
        wait_for(0, "abort_reach_tx");
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_tx_low", 32'(tx_en), 32'd0);
        chk("abort_done_now", 32'(line_done), 32'd1);
        wait_idle("abort_finish");
        chk("abort_tx_cycles",    32'(tx_cyc - s_tx),     32'd2);
        chk("abort_start_cycles", 32'(st_cyc - s_st),     32'd0);
        chk("abort_done_pulses",  32'(done_cyc - s_done), 32'd1);
        chk("abort_busy_cycles",  32'(busy_cyc - s_busy), 32'd7);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
